pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the flat 64-bit combinational CLA.
- Splits a WIDTH-bit operation into STAGES slices. Each slice is a BLOCK-grouped CLA, and carry is registered between slices.
- Valid/ready streaming on both sides sustains one operation per cycle; sits between operand buffers and the ALU result path.

Parameters:
- WIDTH, 64: operand width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth (slices); WIDTH/STAGES must be a multiple of BLOCK.
- BLOCK, 4: CLA group size inside a slice (group P/G lookahead).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (ignored when op=SUB)
- op  in  1  0=ADD, 1=SUB
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result bits
- cout  out  1  carry out of MSB
- overflow  out  1  signed overflow

Behaviour:
- Transfer occurs on a clock edge with valid&&ready; input fields are sampled only at that edge.
- ADD: {cout,sum} = a + b + cin.
- SUB: {cout,sum} = a + ~b + 1. cout=1 means no borrow.
- overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is b after SUB inversion.
- Stage k (0..STAGES-1) computes bits [(k+1)*W/STAGES-1 : k*W/STAGES] from the carry registered by stage k-1:
  - Stage 0 uses cin, or 1 for SUB.
  - Upper operand slices travel in skew registers.
  - Completed lower sum slices travel in deskew registers.
- Each stage has a valid bit v[k]. Stage k loads when !v[k] || move[k+1], where move[STAGES] = out_valid && out_ready.
- in_ready = !v[0] || move[1]. This is a bubble-collapsing chain; the ready path is combinational.
- out_valid = v[STAGES-1]. sum/cout/overflow are registered outputs of the last stage and stay stable while out_valid && !out_ready.
- Latency:
  - Exactly STAGES cycles from input handshake to out_valid with out_ready held high.
  - Throughput 1/cycle; results leave strictly in order.
- Full condition: all v[k]=1 and out_ready=0 gives in_ready=0. A simultaneous output pop and input push in the full state is allowed, with no bubble.
- Wrap-around: all-ones + 1 gives sum=0, cout=1, with no special handling.
- Reset:
  - rst_n low clears all v[k] immediately, so out_valid=0; sum=0, cout=0, overflow=0.
  - In-flight operations are discarded.
  - in_ready=1 during and after reset.
- Data registers may skip reset except the output registers.
- No X propagation from unused data when v=0; output fields are don't-care but driven.

Optional Feature:
- Macro: CLA_PIPE_STATS_EN.
- Defined:
  - Adds output op_count [31:0] counting output handshakes (out_valid && out_ready). It wraps from 0xFFFFFFFF to 0.
  - Adds output stall_count [31:0] counting cycles with out_valid && !out_ready. It saturates at 0xFFFFFFFF.
  - Both counters clear on reset.
- Undefined: the ports and counters are absent, with no behavioural difference otherwise.

Decomposition:
- Package cla_pkg:
  - op_e enum {OP_ADD=0, OP_SUB=1}
  - localparam helper SLICE_W(WIDTH,STAGES)
  - elaboration-time check function for the divisibility rules
- Sub-module cla_slice: combinational, generic width, built from BLOCK-bit group P/G lookahead. Inputs a, b, cin; outputs sum, cout, and msb carry-in for overflow.
- Top instantiates STAGES cla_slice instances plus the valid/skew/deskew registers.

Test Plan:
- Defaults, out_ready=1, back-to-back ADD beats (64+64), (1000000000+1000000000), (123+73), (246+562) -> sums 128, 2000000000, 196, 808 appear 4 cycles after each input, one per cycle, cout=0, overflow=0.
- ADD 0xFFFF_FFFF_FFFF_FFFF + 1, cin=0 -> sum=0, cout=1, overflow=0; and 0x7FFF_FFFF_FFFF_FFFF + 1 -> sum=0x8000_0000_0000_0000, overflow=1, cout=0.
- SUB 5 - 7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; SUB 7 - 5 -> sum=2, cout=1; SUB 0x8000_0000_0000_0000 - 1 -> overflow=1.
- Backpressure: out_ready=0 while issuing 6 beats with in_valid=1 -> in_ready falls after 4 accepted beats. Raise out_ready -> 6 results drain in order, and out fields stay stable while stalled.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 ops in flight -> out_valid drops without a clock edge. After release, in_ready=1, no stale result emerges, and the next op has normal 4-cycle latency.
- With CLA_PIPE_STATS_EN and the backpressure scenario -> op_count=6, stall_count=number of stalled-valid cycles. Repeat with WIDTH=32, STAGES=2, BLOCK=4 -> scenario 1 results identical, latency 2.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // At least two slices; WIDTH splits into whole slices, and each slice into whole groups.
  function automatic bit cfg_ok(input int width, input int stages, input int block);
    if (stages < 2 || block < 1) begin
      return 1'b0;
    end else if ((width % stages) != 0) begin
      return 1'b0;
    end else begin
      return ((width / stages) % block) == 0;
    end
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit adder slice built from BLOCK-bit group generate/propagate lookahead.
module cla_slice
  import cla_pkg::*;
#(
  parameter int W     = 16,
  parameter int BLOCK = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  localparam int NGRP = W / BLOCK;

  logic [W-1:0] p_s;
  logic [W-1:0] g_s;
  logic [W-1:0] c_s;

  assign p_s = a_i ^ b_i;
  assign g_s = a_i & b_i;

  // Bit carries from in-group prefix G/P plus the carry entering each group.
  always_comb begin
    logic grp_c;
    logic pre_g;
    logic pre_p;
    c_s    = '0;
    grp_c  = cin_i;
    pre_g  = 1'b0;
    pre_p  = 1'b1;
    for (int j = 0; j < NGRP; j++) begin
      pre_g = 1'b0;
      pre_p = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        c_s[j*BLOCK+i] = pre_g | (pre_p & grp_c);
        pre_g          = g_s[j*BLOCK+i] | (p_s[j*BLOCK+i] & pre_g);
        pre_p          = pre_p & p_s[j*BLOCK+i];
      end
      grp_c = pre_g | (pre_p & grp_c);
    end
    cout_o = grp_c;
  end

  assign sum_o  = p_s ^ c_s;
  assign cmsb_o = c_s[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: STAGES registered slices with valid/ready flow control.
// Defining CLA_PIPE_STATS_EN adds the op_count / stall_count statistics outputs.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
`ifdef CLA_PIPE_STATS_EN
  ,
  output logic [31:0]      op_count,
  output logic [31:0]      stall_count
`endif
);

  localparam int SW   = slice_w(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_cfg_err
    $error("pipelined_cla_adder: unsupported WIDTH/STAGES/BLOCK combination");
  end

  op_e              op_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;

  assign op_s      = op_e'(op);
  assign b_eff_s   = (op_s == OP_SUB) ? ~b : b;
  assign cin_eff_s = (op_s == OP_SUB) ? 1'b1 : cin;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] load_s;

  // Skew (upper operands) and deskew (finished lower sums) registers between slices.
  logic [WIDTH-1:0] a_q [LAST];
  logic [WIDTH-1:0] b_q [LAST];
  logic [WIDTH-1:0] s_q [LAST];
  logic             c_q [LAST];

  logic [SW-1:0] slc_sum_s  [STAGES];
  logic          slc_cout_s [STAGES];
  logic          slc_cmsb_s [STAGES];

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [SW-1:0] sa_s;
    logic [SW-1:0] sb_s;
    logic          sc_s;
    if (k == 0) begin : g_head
      assign sa_s = a[SW-1:0];
      assign sb_s = b_eff_s[SW-1:0];
      assign sc_s = cin_eff_s;
    end else begin : g_body
      assign sa_s = a_q[k-1][k*SW +: SW];
      assign sb_s = b_q[k-1][k*SW +: SW];
      assign sc_s = c_q[k-1];
    end
    cla_slice #(.W(SW), .BLOCK(BLOCK)) u_slice (
      .a_i    (sa_s),
      .b_i    (sb_s),
      .cin_i  (sc_s),
      .sum_o  (slc_sum_s[k]),
      .cout_o (slc_cout_s[k]),
      .cmsb_o (slc_cmsb_s[k])
    );
  end

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    logic rdy;
    load_s       = '0;
    rdy          = ~v_q[LAST] | out_ready;
    load_s[LAST] = rdy;
    for (int k = LAST - 1; k >= 0; k--) begin
      rdy       = ~v_q[k] | rdy;
      load_s[k] = rdy;
    end
  end

  assign in_ready  = load_s[0];
  assign out_valid = v_q[LAST];

  // Stage occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      if (load_s[0]) v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (load_s[k]) v_q[k] <= v_q[k-1];
      end
    end
  end

  // Inter-slice data; only written when a real beat moves in, so empty stages never inject X.
  always_ff @(posedge clk) begin
    if (load_s[0] && in_valid) begin
      a_q[0] <= a;
      b_q[0] <= b_eff_s;
      c_q[0] <= slc_cout_s[0];
      s_q[0] <= {{(WIDTH-SW){1'b0}}, slc_sum_s[0]};
    end
    for (int k = 1; k < LAST; k++) begin
      if (load_s[k] && v_q[k-1]) begin
        a_q[k]               <= a_q[k-1];
        b_q[k]               <= b_q[k-1];
        c_q[k]               <= slc_cout_s[k];
        s_q[k]               <= s_q[k-1];
        s_q[k][k*SW +: SW]   <= slc_sum_s[k];
      end
    end
  end

  // Result registers; overflow is carry-into-MSB xor carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load_s[LAST] && v_q[LAST-1]) begin
      sum_q  <= {slc_sum_s[LAST], s_q[LAST-1][WIDTH-SW-1:0]};
      cout_q <= slc_cout_s[LAST];
      ovf_q  <= slc_cout_s[LAST] ^ slc_cmsb_s[LAST];
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

`ifdef CLA_PIPE_STATS_EN
  logic [31:0] op_cnt_q;
  logic [31:0] stall_cnt_q;

  // Handshake counter wraps; stall counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (v_q[LAST] && out_ready) op_cnt_q <= op_cnt_q + 32'd1;
      if (v_q[LAST] && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign op_count    = op_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed and random beats against an arithmetic reference queue.
// Build with CLA_PIPE_STATS_EN defined to also check the statistics counters.
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  localparam int W = 64;
  localparam int S = 4;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
`ifdef CLA_PIPE_STATS_EN
  logic [31:0]  op_count;
  logic [31:0]  stall_count;
  logic [31:0]  op_base;
`endif

  pipelined_cla_adder #(.WIDTH(W), .STAGES(S), .BLOCK(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
`ifdef CLA_PIPE_STATS_EN
    ,
    .op_count    (op_count),
    .stall_count (stall_count)
`endif
  );

  typedef struct {
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           t_in;
    bit           lat;
    bit           dir;
    logic [W-1:0] ds;
    logic         dc;
    logic         dov;
  } exp_t;

  exp_t exp_q[$];

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  tb_ops = 0;
  int  tb_stalls = 0;
  bit  lat_chk = 1'b0;
  bit  pend_dir = 1'b0;
  logic [W-1:0] pend_sum = '0;
  logic         pend_cout = 1'b0;
  logic         pend_ovf = 1'b0;
  bit           hs;
  bit           held;
  int           idx;
  int           guard;
  logic [W-1:0] hold_sum;
  logic         hold_cout;
  logic         hold_ovf;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide arithmetic on the architectural rules.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic mop);
    exp_t         e;
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   r;
    bb   = mop ? ~mb : mb;
    c0   = mop ? 1'b1 : mc;
    r    = {1'b0, ma} + {1'b0, bb} + (W+1)'(c0);
    e    = '{default: '0};
    e.es = r[W-1:0];
    e.ec = r[W];
    e.eo = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
    return e;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        e      = model(a, b, cin, op);
        e.t_in = cyc;
        e.lat  = lat_chk;
        e.dir  = pend_dir;
        e.ds   = pend_sum;
        e.dc   = pend_cout;
        e.dov  = pend_ovf;
        exp_q.push_back(e);
      end
      if (out_valid && !out_ready) tb_stalls++;
      if (out_valid && out_ready) begin
        tb_ops++;
        chk("unexpected_result", 128'(exp_q.size() != 0), 128'(1'b1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum", 128'(sum), 128'(e.es));
          chk("cout", 128'(cout), 128'(e.ec));
          chk("overflow", 128'(overflow), 128'(e.eo));
          if (e.lat) chk("latency", 128'(cyc - e.t_in), 128'(S));
          if (e.dir) begin
            chk("dir_sum", 128'(sum), 128'(e.ds));
            chk("dir_cout", 128'(cout), 128'(e.dc));
            chk("dir_ovf", 128'(overflow), 128'(e.dov));
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic top);
    int g;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    op       = top;
    in_valid = 1'b1;
    g        = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("send_timeout", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pend_dir = 1'b0;
  endtask

  task automatic send_d(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic top,
                        input logic [W-1:0] ds, input logic dc, input logic dov);
    pend_dir  = 1'b1;
    pend_sum  = ds;
    pend_cout = dc;
    pend_ovf  = dov;
    send(ta, tb_v, tc, top);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_sum", 128'(sum), 128'(0));
    chk("reset_cout", 128'(cout), 128'(1'b0));
    chk("reset_ovf", 128'(overflow), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back ADD beats with exact latency.
    lat_chk = 1'b1;
    send_d(64'd64, 64'd64, 1'b0, OP_ADD, 64'd128, 1'b0, 1'b0);
    send_d(64'd1000000000, 64'd1000000000, 1'b0, OP_ADD, 64'd2000000000, 1'b0, 1'b0);
    send_d(64'd123, 64'd73, 1'b0, OP_ADD, 64'd196, 1'b0, 1'b0);
    send_d(64'd246, 64'd562, 1'b0, OP_ADD, 64'd808, 1'b0, 1'b0);
    lat_chk = 1'b0;
    drain();

    // Wrap, overflow, subtraction corners, carry-in handling.
    send_d(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, 64'd0, 1'b1, 1'b0);
    send_d(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send_d(64'd5, 64'd7, 1'b0, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send_d(64'd7, 64'd5, 1'b0, OP_SUB, 64'd2, 1'b1, 1'b0);
    send_d(64'h8000_0000_0000_0000, 64'd1, 1'b0, OP_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    send_d(64'd10, 64'd3, 1'b1, OP_SUB, 64'd7, 1'b1, 1'b0);
    send_d(64'd10, 64'd3, 1'b1, OP_ADD, 64'd14, 1'b0, 1'b0);
    drain();

    // Random operands with random valid and ready gaps.
    for (int i = 0; i < 120; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      a         = {$urandom(), $urandom()};
      b         = ($urandom_range(7) == 0) ? {W{1'b1}} : {$urandom(), $urandom()};
      cin       = 1'($urandom_range(1));
      op        = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Backpressure: fill the pipe, hold the result, then drain with push/pop overlap.
`ifdef CLA_PIPE_STATS_EN
    op_base = op_count;
`endif
    out_ready = 1'b0;
    idx       = 0;
    held      = 1'b0;
    a         = 64'd1000;
    b         = 64'd0;
    cin       = 1'b0;
    op        = OP_ADD;
    in_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      if (out_valid) begin
        if (!held) begin
          hold_sum  = sum;
          hold_cout = cout;
          hold_ovf  = overflow;
          held      = 1'b1;
        end else begin
          chk("stall_sum_stable", 128'(sum), 128'(hold_sum));
          chk("stall_cout_stable", 128'(cout), 128'(hold_cout));
          chk("stall_ovf_stable", 128'(overflow), 128'(hold_ovf));
        end
      end
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        a = 64'd1000 + 64'(idx);
        b = 64'(idx) * 64'd3;
      end
    end
    chk("bp_accepted", 128'(idx), 128'(4));
    chk("bp_in_ready_full", 128'(in_ready), 128'(1'b0));
    chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
    out_ready = 1'b1;
    #1;
    chk("full_push_pop_ready", 128'(in_ready), 128'(1'b1));
    guard = 0;
    while (idx < 6 && guard < 20) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        a = 64'd1000 + 64'(idx);
        b = 64'(idx) * 64'd3;
      end
      if (idx >= 6) in_valid = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 128'(idx), 128'(6));
    drain();
`ifdef CLA_PIPE_STATS_EN
    chk("op_count_bp", 128'(op_count - op_base), 128'(6));
    chk("op_count_total", 128'(op_count), 128'(tb_ops));
    chk("stall_count_total", 128'(stall_count), 128'(tb_stalls));
`endif

    // Asynchronous reset with three operations in flight.
    send(64'd11, 64'd22, 1'b0, OP_ADD);
    send(64'd33, 64'd44, 1'b0, OP_ADD);
    send(64'd55, 64'd66, 1'b1, OP_SUB);
    @(posedge clk);
    #1;
    chk("pre_reset_out_valid", 128'(out_valid), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("async_reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("async_reset_sum", 128'(sum), 128'(0));
    chk("async_reset_cout", 128'(cout), 128'(1'b0));
    exp_q.delete();
    tb_ops    = 0;
    tb_stalls = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 128'(in_ready), 128'(1'b1));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_stale_result", 128'(out_valid), 128'(1'b0));
    end
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send_d(64'd123, 64'd73, 1'b0, OP_ADD, 64'd196, 1'b0, 1'b0);
    lat_chk = 1'b0;
    drain();
`ifdef CLA_PIPE_STATS_EN
    chk("op_count_after_reset", 128'(op_count), 128'(tb_ops));
    chk("stall_count_after_reset", 128'(stall_count), 128'(tb_stalls));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
